// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio defaults and PCM-to-PWM duty helpers
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PWM_W_DEF  = 8;
  localparam logic [PWM_W_DEF-1:0] MIDSCALE_DEF = PWM_W_DEF'(1) << (PWM_W_DEF - 1);

  function automatic logic [31:0] midscale(input int pwm_w);
    return 32'd1 << (pwm_w - 1);
  endfunction

  // Top PWM_W bits of a signed sample, MSB inverted: signed -> offset binary.
  function automatic logic [31:0] to_offset(input logic [31:0] sample, input int data_w,
                                            input int pwm_w);
    return (sample >> (data_w - pwm_w)) ^ midscale(pwm_w);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read data and a level counter
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;
  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);

endmodule

// File: rtl/mic_pcm_pwm_player.sv
// rtl/mic_pcm_pwm_player.sv - buffers mic PCM words and plays them as 1-bit PWM
// Define MIC_PWM_HOLD_LAST_EN to keep the previous duty on an empty period instead of midscale.
module mic_pcm_pwm_player
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int PWM_W  = PWM_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       sample_in,
  input  logic                    sample_valid,
  output logic                    pwm_out,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    overflow,
  output logic                    underrun
);

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_cnt_max;
  logic              w_rd_en;
  logic              w_wr_en;
  logic [PWM_W-1:0]  w_duty_new;
  logic [PWM_W-1:0]  w_duty_idle;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [PWM_W-1:0]  r_duty;
  logic              r_pwm_out;
  logic              r_overflow;
  logic              r_underrun;

  assign w_cnt_max  = (r_pwm_cnt == '1);
  assign w_rd_en    = enable && w_cnt_max && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr_en    = enable && sample_valid && (!w_full || w_rd_en);
  assign w_duty_new = PWM_W'(to_offset(32'(w_head), DATA_W, PWM_W));

`ifdef MIC_PWM_HOLD_LAST_EN
  assign w_duty_idle = r_duty;
`else
  assign w_duty_idle = PWM_W'(midscale(PWM_W));
`endif

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_data (sample_in),
    .rd_en   (w_rd_en),
    .rd_data (w_head),
    .level   (fifo_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_pwm_out  <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pwm_out <= enable && (r_pwm_cnt < r_duty);
      if (enable) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        if (w_cnt_max) begin
          if (!w_empty) begin
            r_duty <= w_duty_new;
          end else begin
            r_duty     <= w_duty_idle;
            r_underrun <= 1'b1;
          end
        end
        if (sample_valid && w_full && !w_rd_en) r_overflow <= 1'b1;
      end
    end
  end

  assign pwm_out    = r_pwm_out;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign overflow   = r_overflow;
  assign underrun   = r_underrun;

endmodule
